lw_use_stall_controller: RTL and testbench
==========================================

Name: lw_use_stall_controller

Overview:
- Load-use hazard detection and stall sequencer for the 5-stage MIPS32 pipeline.
- Compares the load in ID/EX against source registers of the instruction in IF/ID.
- Drives the IF-side instruction-hold mux select (lw_use_control_stall), PC/IF-ID write enables and ID/EX bubble insertion.
- Holds the stall for a programmable number of cycles so multi-cycle data memories are covered; branch flush takes priority.

Parameters:
- STALL_CYCLES, 1, total stall cycles per load-use hazard including detection cycle; legal 1..15
- CNT_W, 4, width of internal stall down-counter; must hold STALL_CYCLES-1
- PERF_W, 32, width of performance counters (only with STALL_PERF_CNT_EN)

Ports:
- clk  input  1  pipeline clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- id_ex_mem_read  input  1  instruction in ID/EX is a load (lw)
- id_ex_rt  input  5  destination register of that load
- if_id_rs  input  5  rs field of instruction in IF/ID
- if_id_rt  input  5  rt field of instruction in IF/ID
- if_id_uses_rt  input  1  IF/ID instruction reads rt (R-type, sw, beq/bne)
- branch_taken  input  1  branch/jump resolved taken in EX this cycle
- lw_use_control_stall  output  1  select held IF/ID instruction instead of fetched one
- pc_write_en  output  1  PC register write enable
- if_id_write_en  output  1  IF/ID register write enable
- id_ex_bubble  output  1  zero ID/EX control fields (insert NOP)
- if_id_flush  output  1  clear IF/ID to NOP
- stall_busy  output  1  FSM in STALL state (registered)

Behaviour:
- hazard = id_ex_mem_read & (id_ex_rt != 0) & ((id_ex_rt == if_id_rs) | (if_id_uses_rt & (id_ex_rt == if_id_rt))). Register 0 never hazards.
- States IDLE, STALL; state and cnt registered, reset to IDLE, cnt=0.
- While rst_n=0: lw_use_control_stall=0, pc_write_en=1, if_id_write_en=1, id_ex_bubble=0, if_id_flush=0, stall_busy=0, regardless of inputs. Reset mid-stall aborts stall immediately; first cycle after release is IDLE.
- IDLE, branch_taken=1: if_id_flush=1, id_ex_bubble=1, no stall outputs, remain IDLE. Branch has priority over a simultaneous hazard (the dependent instruction is being flushed).
- IDLE, hazard=1, branch_taken=0: same cycle (combinational) stall=1, pc_write_en=0, if_id_write_en=0, id_ex_bubble=1. If STALL_CYCLES=1 remain IDLE; else next state STALL, cnt=STALL_CYCLES-1.
- IDLE, neither: stall=0, pc_write_en=1, if_id_write_en=1, id_ex_bubble=0, if_id_flush=0.
- STALL: stall outputs asserted as above regardless of hazard/branch_taken (EX holds a bubble, so branch_taken is ignored); cnt decrements each cycle; cycle with cnt=1 is last STALL cycle, then IDLE. stall_busy=1 throughout STALL.
- Back-to-back loads: hazard re-evaluated in IDLE on the first cycle after STALL exits; a new hazard starts a new sequence with no gap cycle.
- Exactly STALL_CYCLES consecutive cycles with lw_use_control_stall=1 per hazard.

Optional Feature:
- Macro STALL_PERF_CNT_EN. Defined: adds outputs lw_use_events [PERF_W-1:0] (increments on each hazard entry from IDLE) and stall_cycles [PERF_W-1:0] (increments every cycle lw_use_control_stall=1); both saturate at all-ones, reset to 0 asynchronously. Undefined: ports and counters absent; remaining behaviour identical.

Test Plan:
- Reset: hold rst_n=0 with id_ex_mem_read=1, id_ex_rt=5, if_id_rs=5 -> all outputs at reset values (pc_write_en=1, stall=0).
- STALL_CYCLES=1: lw $5 in ID/EX, add rs=5 in IF/ID -> stall, bubble, pc_write_en=0 for exactly 1 cycle, then normal.
- STALL_CYCLES=3: same stimulus, hazard input dropped after 1 cycle -> stall=1 for 3 consecutive cycles, stall_busy=1 on cycles 2-3.
- Register 0 and rt-unused: id_ex_rt=0, if_id_rs=0 -> no stall; id_ex_rt=7, if_id_rt=7, if_id_uses_rt=0 -> no stall.
- Simultaneous branch_taken=1 and hazard in IDLE -> if_id_flush=1, id_ex_bubble=1, stall=0, pc_write_en=1.
- Reset asserted in cycle 2 of a 3-cycle stall -> outputs return to reset values immediately; after release, IDLE, no residual stall.

Source files
------------

// File: rtl/lw_use_stall_controller.sv
// lw_use_stall_controller: load-use hazard detection and stall sequencer for a 5-stage MIPS32 pipeline
// Ports:
//   clk, rst_n                       clock (rising edge), asynchronous active-low reset
//   id_ex_mem_read, id_ex_rt         load in ID/EX and its destination register
//   if_id_rs, if_id_rt, if_id_uses_rt source registers of the IF/ID instruction
//   branch_taken                     branch/jump resolved taken in EX
//   lw_use_control_stall             select held IF/ID instruction
//   pc_write_en, if_id_write_en      PC and IF/ID write enables
//   id_ex_bubble, if_id_flush        NOP insertion into ID/EX, IF/ID clear
//   stall_busy                       registered STALL-state flag
// Optional: define STALL_PERF_CNT_EN to add lw_use_events / stall_cycles counters.
module lw_use_stall_controller #(
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W = 4,
  parameter int PERF_W = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic id_ex_mem_read,
  input  logic [4:0] id_ex_rt,
  input  logic [4:0] if_id_rs,
  input  logic [4:0] if_id_rt,
  input  logic if_id_uses_rt,
  input  logic branch_taken,
  output logic lw_use_control_stall,
  output logic pc_write_en,
  output logic if_id_write_en,
  output logic id_ex_bubble,
  output logic if_id_flush,
`ifdef STALL_PERF_CNT_EN
  output logic [PERF_W-1:0] lw_use_events,
  output logic [PERF_W-1:0] stall_cycles,
`endif
  output logic stall_busy
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] STALL = 1'b1;
  logic [0:0] state;
  logic [CNT_W-1:0] cnt;
  logic hazard, in_stall, entry, stall_now, flush_now;
  assign hazard = id_ex_mem_read & (id_ex_rt != 5'd0) &
                  ((id_ex_rt == if_id_rs) | (if_id_uses_rt & (id_ex_rt == if_id_rt)));
  assign in_stall = state == STALL;
  // EX holds a bubble during STALL, so a branch there cannot be real and is ignored.
  assign entry = ~in_stall & hazard & ~branch_taken;
  assign flush_now = ~in_stall & branch_taken;
  assign stall_now = in_stall | entry;
  // Outputs are forced to their reset values for as long as rst_n is low.
  assign lw_use_control_stall = rst_n & stall_now;
  assign pc_write_en = ~(rst_n & stall_now);
  assign if_id_write_en = ~(rst_n & stall_now);
  assign id_ex_bubble = rst_n & (stall_now | flush_now);
  assign if_id_flush = rst_n & flush_now;
  assign stall_busy = in_stall;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
    end else if (in_stall) begin
      state <= cnt == CNT_W'(1) ? IDLE : STALL;
      cnt <= cnt - CNT_W'(1);
    end else if (entry && STALL_CYCLES > 1) begin
      state <= STALL;
      cnt <= CNT_W'(STALL_CYCLES - 1);
    end
  end
`ifdef STALL_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lw_use_events <= '0;
      stall_cycles <= '0;
    end else begin
      if (entry && ~&lw_use_events) lw_use_events <= lw_use_events + PERF_W'(1);
      if (stall_now && ~&stall_cycles) stall_cycles <= stall_cycles + PERF_W'(1);
    end
  end
`endif
endmodule

// File: tb/tb_lw_use_stall_controller.sv
// tb_lw_use_stall_controller: table-driven scoreboard bench for STALL_CYCLES=1 and STALL_CYCLES=3 instances
module tb_lw_use_stall_controller;
  logic clk = 1'b0;
  logic rst_n, mr, uses, br;
  logic [4:0] rt, rs, irt;
  logic [5:0] o1, o3;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] ev1, sc1, ev3, sc3;
`endif
  lw_use_stall_controller #(.STALL_CYCLES(1)) d1 (
    .clk(clk), .rst_n(rst_n), .id_ex_mem_read(mr), .id_ex_rt(rt), .if_id_rs(rs),
    .if_id_rt(irt), .if_id_uses_rt(uses), .branch_taken(br),
    .lw_use_control_stall(o1[5]), .pc_write_en(o1[4]), .if_id_write_en(o1[3]),
    .id_ex_bubble(o1[2]), .if_id_flush(o1[1]),
`ifdef STALL_PERF_CNT_EN
    .lw_use_events(ev1), .stall_cycles(sc1),
`endif
    .stall_busy(o1[0]));
  lw_use_stall_controller #(.STALL_CYCLES(3)) d3 (
    .clk(clk), .rst_n(rst_n), .id_ex_mem_read(mr), .id_ex_rt(rt), .if_id_rs(rs),
    .if_id_rt(irt), .if_id_uses_rt(uses), .branch_taken(br),
    .lw_use_control_stall(o3[5]), .pc_write_en(o3[4]), .if_id_write_en(o3[3]),
    .id_ex_bubble(o3[2]), .if_id_flush(o3[1]),
`ifdef STALL_PERF_CNT_EN
    .lw_use_events(ev3), .stall_cycles(sc3),
`endif
    .stall_busy(o3[0]));
  // Output order: {stall, pc_write_en, if_id_write_en, bubble, flush, busy}
  localparam logic [5:0] N = 6'b011000, S = 6'b100100, SB = 6'b100101, BR = 6'b011110;
  typedef struct {
    logic rst_n, mr;
    logic [4:0] rt, rs, irt;
    logic uses, br;
    logic [5:0] e1, e3;
  } vec_t;
  typedef struct {
    int idx;
    logic [5:0] e1, e3;
  } exp_t;
  vec_t vecs[25];
  exp_t sb[$];
  function automatic vec_t v(logic r, logic m, logic [4:0] a, logic [4:0] b, logic [4:0] c,
                             logic u, logic x, logic [5:0] e1, logic [5:0] e3);
    vec_t t;
    t.rst_n = r; t.mr = m; t.rt = a; t.rs = b; t.irt = c; t.uses = u; t.br = x;
    t.e1 = e1; t.e3 = e3;
    return t;
  endfunction
  task automatic drive(vec_t t);
    rst_n = t.rst_n; mr = t.mr; rt = t.rt; rs = t.rs; irt = t.irt; uses = t.uses; br = t.br;
  endtask
  task automatic check(string name, logic [5:0] act, logic [5:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask
  initial begin
    exp_t e;
    int n;
    bit done;
    vecs[0]  = v(0, 1, 5, 5, 0, 0, 0, N, N);
    vecs[1]  = v(0, 1, 5, 5, 0, 0, 0, N, N);
    vecs[2]  = v(1, 0, 5, 5, 0, 0, 0, N, N);
    vecs[3]  = v(1, 1, 5, 5, 0, 0, 0, S, S);
    vecs[4]  = v(1, 0, 5, 5, 0, 0, 0, N, SB);
    vecs[5]  = v(1, 0, 5, 5, 0, 0, 0, N, SB);
    vecs[6]  = v(1, 0, 0, 0, 0, 0, 0, N, N);
    vecs[7]  = v(1, 1, 0, 0, 0, 1, 0, N, N);
    vecs[8]  = v(1, 1, 7, 3, 7, 0, 0, N, N);
    vecs[9]  = v(1, 1, 7, 3, 7, 1, 0, S, S);
    vecs[10] = v(1, 1, 7, 3, 7, 1, 1, BR, SB);
    vecs[11] = v(1, 0, 7, 3, 7, 1, 0, N, SB);
    vecs[12] = v(1, 1, 5, 5, 0, 0, 0, S, S);
    vecs[13] = v(1, 1, 5, 5, 0, 0, 0, S, SB);
    vecs[14] = v(1, 1, 5, 5, 0, 0, 0, S, SB);
    vecs[15] = v(1, 1, 5, 5, 0, 0, 0, S, S);
    vecs[16] = v(0, 1, 5, 5, 0, 0, 0, N, N);
    vecs[17] = v(1, 0, 5, 5, 0, 0, 0, N, N);
    vecs[18] = v(1, 1, 5, 5, 0, 0, 1, BR, BR);
    vecs[19] = v(1, 0, 5, 5, 0, 0, 0, N, N);
    vecs[20] = v(1, 1, 9, 1, 9, 1, 0, S, S);
    vecs[21] = v(1, 1, 9, 9, 0, 0, 0, S, SB);
    vecs[22] = v(1, 0, 9, 9, 0, 0, 0, N, SB);
    vecs[23] = v(1, 0, 9, 9, 0, 0, 0, N, N);
    vecs[24] = v(1, 0, 5, 5, 0, 0, 0, N, N);
    drive(vecs[0]);
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i]);
      sb.push_back('{i, vecs[i].e1, vecs[i].e3});
      @(negedge clk);
      e = sb.pop_front();
      check($sformatf("vec%0d_sc1", e.idx), o1, e.e1);
      check($sformatf("vec%0d_sc3", e.idx), o3, e.e3);
    end
    // Single-cycle hazard pulse: count consecutive stall cycles on the 3-cycle instance.
    @(posedge clk);
    #1;
    drive(v(1, 1, 12, 12, 0, 0, 0, S, S));
    @(posedge clk);
    #1;
    drive(v(1, 0, 12, 12, 0, 0, 0, N, N));
    n = 1;
    done = 0;
    for (int k = 0; k < 10 && !done; k++) begin
      @(negedge clk);
      if (o3[5]) n++;
      else done = 1;
      @(posedge clk);
      #1;
    end
    tests++;
    if (!done || n != 3) begin
      fails++;
      $display("FAIL stall_run_len: got %0d cycles (ended=%0d) expected 3", n, done);
    end
    @(negedge clk);
    check("post_run_idle_sc3", o3, N);
    check("post_run_idle_sc1", o1, N);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
